// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner codes
// and the latched memory command record.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// slave = arbiter side, master = requesters/memory side.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb.sv
// Round-robin CPU/DMA arbiter in front of a single-port unified memory with
// WAIT extra read-latency cycles. All outputs are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no access; grant a requester when any req is high
// ST_ACCESS | memory enabled for WAIT+1 cycles using the latched command
// ST_DONE   | one-cycle ready pulse to the owner, then back to idle
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int WAIT = 1
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              dma_ready_q, dma_ready_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic     grant_dma;
  owner_e   grant_own;
  mem_cmd_t grant_cmd;

  // DMA wins if it is alone, or on a tie when the CPU was granted last.
  assign grant_dma = bus.dma_req && (!bus.cpu_req || (last_q == OWN_CPU));
  assign grant_own = grant_dma ? OWN_DMA : OWN_CPU;
  assign grant_cmd = grant_dma ? '{we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata}
                               : '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cmd_d       = cmd_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          state_d     = ST_ACCESS;
          cnt_d       = '0;
          owner_d     = grant_own;
          last_d      = grant_own;
          cmd_d       = grant_cmd;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_cmd.we;
          mem_addr_d  = grant_cmd.addr;
          mem_wdata_d = grant_cmd.wdata;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == WAIT_C) begin
          state_d = ST_DONE;
          if (owner_q == OWN_CPU) begin
            cpu_ready_d = 1'b1;
            if (!cmd_q.we) cpu_rdata_d = bus.mem_rdata;
          end else begin
            dma_ready_d = 1'b1;
            if (!cmd_q.we) dma_rdata_d = bus.mem_rdata;
          end
        end else begin
          // Write strobe is only issued on entry; later cycles just hold the bus.
          cnt_d       = cnt_q + 1'b1;
          mem_en_d    = 1'b1;
          mem_addr_d  = cmd_q.addr;
          mem_wdata_d = cmd_q.wdata;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DMA;
      cmd_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cmd_q       <= cmd_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.dma_ready = dma_ready_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a per-cycle vector table on a WAIT=1 instance plus
// hand-written multi-cycle sequences on WAIT=3 and WAIT=0 instances.
module tb_mem_arb;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mem_arb_if b1 ();
  mem_arb_if b3 ();
  mem_arb_if b0 ();

  mem_arb #(.WAIT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arb #(.WAIT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  mem_arb #(.WAIT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wd;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] m_rd;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_cr;
    logic        e_dr;
    logic [31:0] e_crd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic c_req, logic c_we, logic [31:0] c_addr, logic [31:0] c_wd,
                              logic d_req, logic [31:0] d_addr, logic [31:0] m_rd,
                              logic e_en, logic e_we, logic [31:0] e_addr, logic [31:0] e_wd,
                              logic e_cr, logic e_dr, logic [31:0] e_crd, logic [31:0] e_drd);
    vec_t v;
    v.c_req = c_req; v.c_we = c_we; v.c_addr = c_addr; v.c_wd = c_wd;
    v.d_req = d_req; v.d_addr = d_addr; v.m_rd = m_rd;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_cr = e_cr; v.e_dr = e_dr; v.e_crd = e_crd; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus(input int which);
    case (which)
      1: begin b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
               b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = 0; b1.dma_wdata = 0; b1.mem_rdata = 0; end
      3: begin b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
               b3.dma_req = 0; b3.dma_we = 0; b3.dma_addr = 0; b3.dma_wdata = 0; b3.mem_rdata = 0; end
      default: begin b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
               b0.dma_req = 0; b0.dma_we = 0; b0.dma_addr = 0; b0.dma_wdata = 0; b0.mem_rdata = 0; end
    endcase
  endtask

  initial begin
    int en_n, we_n, rdy_n, drdy_n, crdy_n, rdy_at, dbl, bad_gap, last_rdy;
    logic prev_en;
    logic [31:0] cur_rd;

    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle_bus(1); idle_bus(3); idle_bus(0);

    // CPU/DMA tie, lone CPU read, second tie, CPU write with inputs changed mid-access
    vecs[0]  = mk(1,0,32'h100,0, 1,32'h200, 32'hAAAA0001, 1,0,32'h100,0, 0,0, 0,0);
    vecs[1]  = mk(1,0,32'h100,0, 1,32'h200, 32'hAAAA0001, 1,0,32'h100,0, 0,0, 0,0);
    vecs[2]  = mk(1,0,32'h100,0, 1,32'h200, 32'hAAAA0001, 0,0,0,0, 1,0, 32'hAAAA0001,0);
    vecs[3]  = mk(0,0,0,0,       1,32'h200, 32'hBBBB0002, 0,0,0,0, 0,0, 32'hAAAA0001,0);
    vecs[4]  = mk(0,0,0,0,       1,32'h200, 32'hBBBB0002, 1,0,32'h200,0, 0,0, 32'hAAAA0001,0);
    vecs[5]  = mk(0,0,0,0,       1,32'h200, 32'hBBBB0002, 1,0,32'h200,0, 0,0, 32'hAAAA0001,0);
    vecs[6]  = mk(0,0,0,0,       1,32'h200, 32'hBBBB0002, 0,0,0,0, 0,1, 32'hAAAA0001,32'hBBBB0002);
    vecs[7]  = mk(0,0,0,0,       0,0,       32'hDEADBEEF, 0,0,0,0, 0,0, 32'hAAAA0001,32'hBBBB0002);
    vecs[8]  = mk(1,0,32'h10,0,  0,0,       32'hDEADBEEF, 1,0,32'h10,0, 0,0, 32'hAAAA0001,32'hBBBB0002);
    vecs[9]  = mk(1,0,32'h10,0,  0,0,       32'hDEADBEEF, 1,0,32'h10,0, 0,0, 32'hAAAA0001,32'hBBBB0002);
    vecs[10] = mk(1,0,32'h10,0,  0,0,       32'hDEADBEEF, 0,0,0,0, 1,0, 32'hDEADBEEF,32'hBBBB0002);
    vecs[11] = mk(0,0,0,0,       0,0,       32'hDEADBEEF, 0,0,0,0, 0,0, 32'hDEADBEEF,32'hBBBB0002);
    vecs[12] = mk(1,0,32'h300,0, 1,32'h400, 32'hCCCC0003, 1,0,32'h400,0, 0,0, 32'hDEADBEEF,32'hBBBB0002);
    vecs[13] = mk(1,0,32'h300,0, 1,32'h400, 32'hCCCC0003, 1,0,32'h400,0, 0,0, 32'hDEADBEEF,32'hBBBB0002);
    vecs[14] = mk(1,0,32'h300,0, 1,32'h400, 32'hCCCC0003, 0,0,0,0, 0,1, 32'hDEADBEEF,32'hCCCC0003);
    vecs[15] = mk(1,0,32'h300,0, 0,0,       32'hDDDD0004, 0,0,0,0, 0,0, 32'hDEADBEEF,32'hCCCC0003);
    vecs[16] = mk(1,0,32'h300,0, 0,0,       32'hDDDD0004, 1,0,32'h300,0, 0,0, 32'hDEADBEEF,32'hCCCC0003);
    vecs[17] = mk(1,0,32'h300,0, 0,0,       32'hDDDD0004, 1,0,32'h300,0, 0,0, 32'hDEADBEEF,32'hCCCC0003);
    vecs[18] = mk(1,0,32'h300,0, 0,0,       32'hDDDD0004, 0,0,0,0, 1,0, 32'hDDDD0004,32'hCCCC0003);
    vecs[19] = mk(0,0,0,0,       0,0,       32'hDDDD0004, 0,0,0,0, 0,0, 32'hDDDD0004,32'hCCCC0003);
    vecs[20] = mk(1,1,32'h20,32'h5555AAAA, 0,0, 32'hEEEE0005, 1,1,32'h20,32'h5555AAAA, 0,0, 32'hDDDD0004,32'hCCCC0003);
    vecs[21] = mk(1,0,32'h99,0,  0,0,       32'hEEEE0005, 1,0,32'h20,32'h5555AAAA, 0,0, 32'hDDDD0004,32'hCCCC0003);
    vecs[22] = mk(1,0,32'h99,0,  0,0,       32'hEEEE0005, 0,0,0,0, 1,0, 32'hDDDD0004,32'hCCCC0003);
    vecs[23] = mk(0,0,0,0,       0,0,       32'hEEEE0005, 0,0,0,0, 0,0, 32'hDDDD0004,32'hCCCC0003);

    repeat (2) @(negedge clk);
    chk("rst.mem_en",    {31'b0, b1.mem_en},    0);
    chk("rst.mem_addr",  b1.mem_addr,           0);
    chk("rst.cpu_ready", {31'b0, b1.cpu_ready}, 0);
    chk("rst.cpu_rdata", b1.cpu_rdata,          0);
    chk("rst.dma_rdata", b3.dma_rdata,          0);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      b1.cpu_req = vecs[i].c_req; b1.cpu_we = vecs[i].c_we;
      b1.cpu_addr = vecs[i].c_addr; b1.cpu_wdata = vecs[i].c_wd;
      b1.dma_req = vecs[i].d_req; b1.dma_we = 1'b0;
      b1.dma_addr = vecs[i].d_addr; b1.dma_wdata = 32'h0;
      b1.mem_rdata = vecs[i].m_rd;
      @(negedge clk);
      chk($sformatf("v%0d.mem_en", i),    {31'b0, b1.mem_en},    {31'b0, vecs[i].e_en});
      chk($sformatf("v%0d.mem_we", i),    {31'b0, b1.mem_we},    {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d.mem_addr", i),  b1.mem_addr,           vecs[i].e_addr);
      chk($sformatf("v%0d.mem_wdata", i), b1.mem_wdata,          vecs[i].e_wd);
      chk($sformatf("v%0d.cpu_ready", i), {31'b0, b1.cpu_ready}, {31'b0, vecs[i].e_cr});
      chk($sformatf("v%0d.dma_ready", i), {31'b0, b1.dma_ready}, {31'b0, vecs[i].e_dr});
      chk($sformatf("v%0d.cpu_rdata", i), b1.cpu_rdata,          vecs[i].e_crd);
      chk($sformatf("v%0d.dma_rdata", i), b1.dma_rdata,          vecs[i].e_drd);
    end
    idle_bus(1);

    // WAIT=3 DMA write
    b3.dma_req = 1; b3.dma_we = 1; b3.dma_addr = 32'h40; b3.dma_wdata = 32'h12345678;
    b3.mem_rdata = 32'hFFFF0000;
    en_n = 0; we_n = 0; rdy_n = 0; crdy_n = 0; rdy_at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("wr.first_we",    {31'b0, b3.mem_we}, 1);
        chk("wr.mem_addr",    b3.mem_addr,        32'h40);
        chk("wr.mem_wdata",   b3.mem_wdata,       32'h12345678);
      end
      en_n += int'(b3.mem_en);
      we_n += int'(b3.mem_we);
      crdy_n += int'(b3.cpu_ready);
      if (b3.dma_ready) begin
        rdy_n++;
        if (rdy_at < 0) rdy_at = k;
        b3.dma_req = 0;
      end
    end
    chk("wr.en_cycles",  en_n,         4);
    chk("wr.we_cycles",  we_n,         1);
    chk("wr.dma_ready",  rdy_n,        1);
    chk("wr.ready_at",   rdy_at,       4);
    chk("wr.cpu_ready",  crdy_n,       0);
    chk("wr.dma_rdata",  b3.dma_rdata, 0);
    b3.dma_we = 0; b3.dma_addr = 0; b3.dma_wdata = 0;

    // WAIT=0 back-to-back CPU reads with req held
    b0.cpu_req = 1; b0.cpu_addr = 32'h30;
    cur_rd = 32'h50000000; b0.mem_rdata = cur_rd;
    en_n = 0; rdy_n = 0; dbl = 0; bad_gap = 0; last_rdy = -1; prev_en = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      en_n += int'(b0.mem_en);
      if (b0.mem_en && prev_en) dbl++;
      prev_en = b0.mem_en;
      if (b0.cpu_ready) begin
        rdy_n++;
        if (last_rdy >= 0 && k - last_rdy != 3) bad_gap++;
        last_rdy = k;
        chk($sformatf("b2b.rdata_k%0d", k), b0.cpu_rdata, cur_rd);
      end
      cur_rd = 32'h50000000 + 32'(k + 1);
      b0.mem_rdata = cur_rd;
      if (k == 10) b0.cpu_req = 0;
    end
    chk("b2b.ready_count", rdy_n,   4);
    chk("b2b.en_count",    en_n,    4);
    chk("b2b.en_runs",     dbl,     0);
    chk("b2b.ready_gap",   bad_gap, 0);
    chk("b2b.last_ready",  last_rdy, 10);
    en_n = 0;
    repeat (2) begin
      @(negedge clk);
      en_n += int'(b0.mem_en);
    end
    chk("b2b.idle_after", en_n, 0);

    // WAIT=3 CPU read with req dropped after the first access cycle
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 32'h44; b3.mem_rdata = 32'hFFFF0000;
    en_n = 0; rdy_n = 0; drdy_n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) b3.cpu_req = 0;
      en_n += int'(b3.mem_en);
      rdy_n += int'(b3.cpu_ready);
      drdy_n += int'(b3.dma_ready);
    end
    chk("drop.en_cycles", en_n,         4);
    chk("drop.cpu_ready", rdy_n,        1);
    chk("drop.dma_ready", drdy_n,       0);
    chk("drop.cpu_rdata", b3.cpu_rdata, 32'hFFFF0000);

    // WAIT=1 reset during the second cycle of a DMA write
    b1.dma_req = 1; b1.dma_we = 1; b1.dma_addr = 32'h80; b1.dma_wdata = 32'h77;
    @(negedge clk);
    chk("rstmid.pre_en", {31'b0, b1.mem_en}, 1);
    @(negedge clk);
    rst = 1'b0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = 0; b1.dma_wdata = 0;
    #1;
    chk("rstmid.mem_en",    {31'b0, b1.mem_en},    0);
    chk("rstmid.mem_we",    {31'b0, b1.mem_we},    0);
    chk("rstmid.mem_addr",  b1.mem_addr,           0);
    chk("rstmid.mem_wdata", b1.mem_wdata,          0);
    chk("rstmid.ready",     {30'b0, b1.cpu_ready, b1.dma_ready}, 0);
    chk("rstmid.cpu_rdata", b1.cpu_rdata,          0);
    chk("rstmid.dma_rdata", b1.dma_rdata,          0);
    @(negedge clk);
    rst = 1'b1;
    b1.cpu_req = 1; b1.cpu_addr = 32'h111;
    b1.dma_req = 1; b1.dma_addr = 32'h222;
    @(negedge clk);
    chk("rstmid.tie_en",   {31'b0, b1.mem_en}, 1);
    chk("rstmid.tie_addr", b1.mem_addr,        32'h111);
    b1.cpu_req = 0; b1.dma_req = 0;
    en_n = 0; we_n = 0; rdy_n = 0; drdy_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      en_n += int'(b1.mem_en);
      we_n += int'(b1.mem_we);
      rdy_n += int'(b1.cpu_ready);
      drdy_n += int'(b1.dma_ready);
    end
    chk("rstmid.en_rest",   en_n,   1);
    chk("rstmid.no_retry",  we_n,   0);
    chk("rstmid.cpu_ready", rdy_n,  1);
    chk("rstmid.dma_ready", drdy_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
